// File: rtl/serial_subtractor_if.sv
// Start/operand/result bundle for serial_subtractor.
// Defining SERSUB_FLAGS_EN adds the zero/ovf result flags.
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] d;
   logic             bout;
`ifdef SERSUB_FLAGS_EN
   logic             zero;
   logic             ovf;

   modport master (
      output start, a, b, bin,
      input  busy, done, d, bout, zero, ovf
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, d, bout, zero, ovf
   );
`else
   modport master (
      output start, a, b, bin,
      input  busy, done, d, bout
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, d, bout
   );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor step per clock.
// Defining SERSUB_FLAGS_EN adds registered zero/ovf flags.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   serial_subtractor_if.slave  bus_io
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;

   // Full-subtractor cell on the current bit
   logic             fs_a, fs_b, fs_d, fs_bo;
   logic [WIDTH-1:0] sr_shift;

   assign fs_a     = sa_q[0];
   assign fs_b     = sb_q[0];
   assign fs_d     = fs_a ^ fs_b ^ br_q;
   assign fs_bo    = (~fs_a & fs_b) | (~(fs_a ^ fs_b) & br_q);
   assign sr_shift = {fs_d, sr_q[WIDTH-1:1]};

`ifdef SERSUB_FLAGS_EN
   logic am_q, am_d, bm_q, bm_d, zero_q, zero_d, ovf_q, ovf_d;
`endif

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      sr_d    = sr_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      bout_d  = bout_q;
`ifdef SERSUB_FLAGS_EN
      am_d    = am_q;
      bm_d    = bm_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus_io.start) begin
               sa_d    = bus_io.a;
               sb_d    = bus_io.b;
               br_d    = bus_io.bin;
               sr_d    = '0;
               cnt_d   = '0;
`ifdef SERSUB_FLAGS_EN
               // Operand MSBs kept apart since sa/sb are shifted away
               am_d    = bus_io.a[WIDTH-1];
               bm_d    = bus_io.b[WIDTH-1];
`endif
               state_d = StRun;
            end
         end
         StRun: begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            br_d  = fs_bo;
            sr_d  = sr_shift;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
               d_d     = sr_shift;
               bout_d  = fs_bo;
`ifdef SERSUB_FLAGS_EN
               zero_d  = (sr_shift == '0);
               ovf_d   = (am_q != bm_q) && (sr_shift[WIDTH-1] != am_q);
`endif
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         sa_q    <= '0;
         sb_q    <= '0;
         sr_q    <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
`ifdef SERSUB_FLAGS_EN
         am_q    <= 1'b0;
         bm_q    <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         sr_q    <= sr_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
`ifdef SERSUB_FLAGS_EN
         am_q    <= am_d;
         bm_q    <= bm_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign bus_io.busy = (state_q == StRun);
   assign bus_io.done = (state_q == StDone);
   assign bus_io.d    = d_q;
   assign bus_io.bout = bout_q;
`ifdef SERSUB_FLAGS_EN
   assign bus_io.zero = zero_q;
   assign bus_io.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor; results queued at start, checked on done.
// Flag checks are included when SERSUB_FLAGS_EN is defined.
module tb_serial_subtractor;

   localparam int unsigned WIDTH = 8;

   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic             bout;
      logic             zero;
      logic             ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   errors   = 0;
   int   done_cnt = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic bin);
      logic [WIDTH:0] diff;
      exp_t           e;
      diff   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
      e.d    = diff[WIDTH-1:0];
      e.bout = diff[WIDTH];
      e.zero = (e.d == '0);
      e.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (e.d[WIDTH-1] != a[WIDTH-1]);
      return e;
   endfunction

   // Scoreboard: every done pulse must match the oldest outstanding request
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            check_eq("unexpected_done", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq("sb_d", 32'(bus.d), 32'(mon_e.d));
            check_eq("sb_bout", 32'(bus.bout), 32'(mon_e.bout));
`ifdef SERSUB_FLAGS_EN
            check_eq("sb_zero", 32'(bus.zero), 32'(mon_e.zero));
            check_eq("sb_ovf", 32'(bus.ovf), 32'(mon_e.ovf));
`endif
         end
      end
   end

   // Counts negedges until done is seen, bounded by limit
   task automatic wait_done(input int limit, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.done && n < limit);
      if (!bus.done) check_eq("done_timeout", 0, 1);
   endtask

   // Called at a negedge with the DUT idle
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                         input string tag);
      int n;
      bus.a     = a;
      bus.b     = b;
      bus.bin   = bin;
      bus.start = 1'b1;
      exp_q.push_back(model(a, b, bin));
      @(negedge clk);
      bus.start = 1'b0;
      check_eq({tag, "_busy"}, 32'(bus.busy), 1);
      wait_done(WIDTH + 4, n);
      check_eq({tag, "_latency"}, 32'(n), WIDTH);
      @(negedge clk);
      check_eq({tag, "_done_pulse"}, 32'(bus.done), 0);
      check_eq({tag, "_idle"}, 32'(bus.busy), 0);
   endtask

   int n;
   int done_before;

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bin   = 1'b0;
      #2;
      check_eq("rst_busy", 32'(bus.busy), 0);
      check_eq("rst_done", 32'(bus.done), 0);
      check_eq("rst_d", 32'(bus.d), 0);
      check_eq("rst_bout", 32'(bus.bout), 0);
`ifdef SERSUB_FLAGS_EN
      check_eq("rst_zero", 32'(bus.zero), 0);
      check_eq("rst_ovf", 32'(bus.ovf), 0);
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_op(8'h5A, 8'h3C, 1'b0, "basic");
      run_op(8'h00, 8'h01, 1'b0, "wrap");
      run_op(8'h10, 8'h0F, 1'b1, "zero");
      run_op(8'h80, 8'h01, 1'b0, "ovf_pos");
      run_op(8'h7F, 8'hFF, 1'b0, "ovf_neg");

      // start re-pulsed mid-RUN must be ignored
      done_before = done_cnt;
      bus.a     = 8'h5A;
      bus.b     = 8'h3C;
      bus.bin   = 1'b0;
      bus.start = 1'b1;
      exp_q.push_back(model(8'h5A, 8'h3C, 1'b0));
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      bus.a     = 8'hFF;
      bus.b     = 8'h00;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(WIDTH + 4, n);
      check_eq("ignore_latency", 32'(n), WIDTH - 3);
      repeat (3) @(negedge clk);
      check_eq("ignore_idle", 32'(bus.busy), 0);
      check_eq("ignore_one_done", 32'(done_cnt - done_before), 1);

      // start held high: one result every WIDTH+2 cycles
      bus.a     = 8'h05;
      bus.b     = 8'h03;
      bus.bin   = 1'b0;
      bus.start = 1'b1;
      exp_q.push_back(model(8'h05, 8'h03, 1'b0));
      for (int p = 0; p < 3; p++) begin
         if (p == 0) begin
            wait_done(WIDTH + 4, n);
            check_eq("held_first", 32'(n), WIDTH + 1);
         end else begin
            repeat (5) @(negedge clk);
            check_eq("held_d_stable", 32'(bus.d), 32'h02);
            wait_done(WIDTH + 4, n);
            check_eq("held_period", 32'(n + 5), WIDTH + 2);
         end
         if (p < 2) exp_q.push_back(model(8'h05, 8'h03, 1'b0));
         else bus.start = 1'b0;
      end
      repeat (2) @(negedge clk);
      check_eq("held_stop", 32'(bus.busy), 0);

      // asynchronous reset during RUN aborts without a done pulse
      bus.a     = 8'h5A;
      bus.b     = 8'h3C;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("abort_busy", 32'(bus.busy), 0);
      check_eq("abort_d", 32'(bus.d), 0);
      check_eq("abort_bout", 32'(bus.bout), 0);
      exp_q.delete();
      done_before = done_cnt;
      @(negedge clk);
      rst = 1'b0;
      repeat (WIDTH + 2) @(negedge clk);
      check_eq("abort_no_done", 32'(done_cnt - done_before), 0);
      run_op(8'h20, 8'h01, 1'b0, "after_abort");

      for (int i = 0; i < 6; i++) begin
         run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "rand");
      end

      repeat (2) @(negedge clk);
      check_eq("queue_drained", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor that computes d = a - b - bin, LSB first, one bit per clock.
- Each bit goes through one instance of the team's FS full-subtractor cell (A, B, Bi -> D, B0). A borrow flip-flop carries the borrow between bits.
- Upstream sequencing stage for the FS cell: it feeds the cell operand bits and consumes the cell's D/B0.
- Used where area matters more than latency; exposes a start/busy/done handshake to the controlling block.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; latched when start is accepted.
- b  input  WIDTH  subtrahend; latched when start is accepted.
- bin  input  1  borrow-in; latched when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse, high while in DONE.
- d  output  WIDTH  difference; registered, held until the next completion.
- bout  output  1  final borrow-out; registered, held until the next completion.
- zero  output  1  (SERSUB_FLAGS_EN only) d == 0.
- ovf  output  1  (SERSUB_FLAGS_EN only) signed overflow of a - b - bin.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; all shift registers, counter and borrow flip-flop cleared.
  - d = 0, bout = 0, busy = 0, done = 0 (zero = 0, ovf = 0 when compiled in).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start = 1 at edge k: sa <= a, sb <= b, br <= bin, sr <= 0, cnt <= 0; go to RUN.
  - start = 0: stay in IDLE.
- RUN, each edge:
  - FS cell inputs: A = sa[0], B = sb[0], Bi = br.
  - sa and sb shift right by one; br <= B0.
  - sr <= {D, sr[WIDTH-1:1]}, so the LSB result bit enters at the MSB and ends at bit 0 after WIDTH shifts.
  - cnt <= cnt + 1. cnt is $clog2(WIDTH+1) bits wide and never wraps within an operation.
  - On the edge where cnt == WIDTH-1 (the WIDTH-th bit): d <= final sr value including this bit, bout <= B0 of this bit; go to DONE.
- DONE: lasts exactly one cycle, then returns to IDLE.
- Latency:
  - start accepted at edge k; busy high between edges k and k+WIDTH.
  - done high between edges k+WIDTH and k+WIDTH+1.
  - d/bout valid from edge k+WIDTH.
- Output decode: busy = (state == RUN), done = (state == DONE); both decoded from registered state, glitch-free.
- start while in RUN or DONE is ignored: no restart, operands not relatched.
- start held high continuously: a new operation is accepted in the first IDLE cycle after DONE, giving back-to-back throughput of one result per WIDTH+2 cycles.
- d/bout change only on the RUN->DONE edge. They stay stable through IDLE and through the next RUN.
- a, b and bin may change freely after acceptance.
- Reset asserted mid-RUN: operation aborted immediately; all outputs return to reset values. No done pulse is issued for the aborted operation.
- Arithmetic is modulo 2^WIDTH: d = (a - b - bin) mod 2^WIDTH; bout = 1 iff a < b + bin (unsigned).

Optional Feature:
- Macro: SERSUB_FLAGS_EN.
- Defined:
  - Ports zero and ovf exist and are registered on the same edge as d.
  - zero = (result == 0).
  - ovf = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]), using the latched operand MSBs, which are captured separately at acceptance.
  - Both clear on reset.
- Undefined: zero and ovf ports and the MSB capture logic are absent; all other behaviour is identical.

Test Plan (WIDTH = 8):
- a=0x5A, b=0x3C, bin=0, start pulse at edge 0 -> busy for 8 cycles; done pulse after edge 8; d=0x1E, bout=0.
- a=0x00, b=0x01, bin=0 -> d=0xFF, bout=1; then a=0x10, b=0x0F, bin=1 -> d=0x00, bout=0 (zero=1 with SERSUB_FLAGS_EN).
- start pulsed again at cycle 3 of RUN with a=0xFF, b=0x00 -> ignored; the first operation completes with its original result and exactly one done pulse.
- start held high with a=0x05, b=0x03, bin=0 -> done pulses every 10 cycles; d=0x02 each time; d stable between pulses.
- rst asserted in cycle 4 of RUN -> busy=0, d=0, bout=0 immediately (asynchronous); no done pulse; a subsequent start of 0x20-0x01 gives d=0x1F.
- SERSUB_FLAGS_EN: a=0x80, b=0x01, bin=0 -> d=0x7F, bout=0, ovf=1, zero=0; a=0x7F, b=0xFF -> d=0x80, bout=1, ovf=1.
